// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for fetch, decode and immediate generation.
// IFU_MISALIGN_FAULT_EN adds a fault bit to the fetch buffer entry.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
`ifdef IFU_MISALIGN_FAULT_EN
        logic            fault;
`endif
    } ifu_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read bus: request channel with ready, response channel without back-pressure.
interface instruction_fetch_unit_if;
    import riscv_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/instruction_fetch_unit_fifo.sv
// ifu_fifo: registered prefetch buffer of fetch entries with synchronous flush.
module ifu_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  ifu_entry_t    wdata,
    input  logic          pop,
    input  logic          flush,
    output ifu_entry_t    rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          push_en, pop_en;

    // NOTE: entry storage has no reset; the count alone says which slots are live.
    ifu_entry_t slot_mem [DEPTH];

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = slot_mem[rd_ptr_q];

    assign pop_en  = pop && !empty && !flush;
    assign push_en = push && !flush && (!full || pop_en);

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push_en && !pop_en)      count_d = count_q + CW'(1);
            else if (pop_en && !push_en) count_d = count_q - CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) slot_mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, credit-limited imem issue, in-order response buffering, redirect flush.
// IFU_MISALIGN_FAULT_EN adds if_fault and turns a misaligned redirect into a faulting NOP entry.
module instruction_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    instruction_fetch_unit_if.master  imem,
    input  logic                      redirect_valid,
    input  logic [XLEN-1:0]           redirect_pc,
    output logic                      if_valid,
    input  logic                      if_ready,
    output logic [XLEN-1:0]           if_pc,
    output logic [XLEN-1:0]           if_instr
`ifdef IFU_MISALIGN_FAULT_EN
    ,
    output logic                      if_fault
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q,   rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   kill_q, kill_d;
`ifdef IFU_MISALIGN_FAULT_EN
    logic            halt_q, halt_d;
    logic            fault_pend_q, fault_pend_d;
`endif

    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count;
    ifu_entry_t      fifo_wdata, fifo_rdata;
    logic [CW:0]     in_use, credit_limit;
    logic            halted, req_valid, req_fire;

`ifdef IFU_MISALIGN_FAULT_EN
    assign halted = halt_q;
`else
    assign halted = 1'b0;
`endif

    // A slot being popped this cycle counts as free, which sustains one fetch per cycle.
    assign fifo_pop     = if_valid && if_ready;
    assign in_use       = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign credit_limit = DEPTH_W + {{CW{1'b0}}, fifo_pop};
    assign req_valid    = rst_n && !redirect_valid && !halted && (in_use < credit_limit);
    assign req_fire     = req_valid && imem.imem_req_ready;

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = fetch_pc_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        kill_d        = kill_q;
        fifo_push     = 1'b0;
        fifo_wdata    = '0;
`ifdef IFU_MISALIGN_FAULT_EN
        halt_d        = halt_q;
        fault_pend_d  = fault_pend_q;
`endif
        if (redirect_valid) begin
            // Every read still in flight belongs to the old path; one arriving now is dropped here.
            fetch_pc_d    = align_word(redirect_pc);
            rsp_pc_d      = align_word(redirect_pc);
            outstanding_d = outstanding_q - CW'(imem.imem_rsp_valid);
            kill_d        = outstanding_q - CW'(imem.imem_rsp_valid);
`ifdef IFU_MISALIGN_FAULT_EN
            halt_d       = (redirect_pc[1:0] != 2'b00);
            fault_pend_d = (redirect_pc[1:0] != 2'b00);
            if (redirect_pc[1:0] != 2'b00) rsp_pc_d = redirect_pc;
`endif
        end else begin
            if (req_fire) begin
                fetch_pc_d    = fetch_pc_q + 32'd4;
                outstanding_d = outstanding_q + CW'(1);
            end
            if (imem.imem_rsp_valid) begin
                outstanding_d = outstanding_d - CW'(1);
                if (kill_q != '0) begin
                    kill_d = kill_q - CW'(1);
                end else begin
                    fifo_push        = 1'b1;
                    fifo_wdata.pc    = rsp_pc_q;
                    fifo_wdata.instr = imem.imem_rsp_data;
                    rsp_pc_d         = rsp_pc_q + 32'd4;
                end
            end
`ifdef IFU_MISALIGN_FAULT_EN
            if (fault_pend_q) begin
                fifo_push        = 1'b1;
                fifo_wdata.pc    = rsp_pc_q;
                fifo_wdata.instr = NOP_INSTR;
                fifo_wdata.fault = 1'b1;
                fault_pend_d     = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            kill_q        <= '0;
`ifdef IFU_MISALIGN_FAULT_EN
            halt_q        <= 1'b0;
            fault_pend_q  <= 1'b0;
`endif
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            kill_q        <= kill_d;
`ifdef IFU_MISALIGN_FAULT_EN
            halt_q        <= halt_d;
            fault_pend_q  <= fault_pend_d;
`endif
        end
    end

    ifu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .flush (redirect_valid),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign if_valid = !fifo_empty;
    assign if_pc    = if_valid ? fifo_rdata.pc    : '0;
    assign if_instr = if_valid ? fifo_rdata.instr : '0;
`ifdef IFU_MISALIGN_FAULT_EN
    assign if_fault = if_valid && fifo_rdata.fault;
`endif

    // The credit rule must keep a slot free for every response that is accepted.
    assert property (@(posedge clk) disable iff (!rst_n) !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: streaming, stall, redirects, PC wrap, mid-run reset.
// IFU_MISALIGN_FAULT_EN selects the misaligned-redirect fault scenario.
module tb_instruction_fetch_unit;
    import riscv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_ready, if_ready_b;
    logic        if_valid, if_valid_b;
    logic [31:0] if_pc, if_pc_b, if_instr, if_instr_b;
`ifdef IFU_MISALIGN_FAULT_EN
    logic        if_fault, if_fault_b;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_pops   = 0;
    int          lat      = 1;
    int          cyc_a    = 0;
    bit          mon_en   = 1'b1;
    logic [31:0] exp_pc   = 32'h0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend_a[$];

    instruction_fetch_unit_if imem_a ();
    instruction_fetch_unit_if imem_b ();

    instruction_fetch_unit u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (imem_a),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
`ifdef IFU_MISALIGN_FAULT_EN
        ,
        .if_fault       (if_fault)
`endif
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (imem_b),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .if_valid       (if_valid_b),
        .if_ready       (if_ready_b),
        .if_pc          (if_pc_b),
        .if_instr       (if_instr_b)
`ifdef IFU_MISALIGN_FAULT_EN
        ,
        .if_fault       (if_fault_b)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        @(negedge clk);
        while (!if_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(if_valid), 32'd1);
    endtask

    // Memory A: in-order responses after a programmable latency.
    always @(posedge clk) begin
        if (!rst_n) begin
            pend_a.delete();
            cyc_a = 0;
            #1;
            imem_a.imem_rsp_valid = 1'b0;
            imem_a.imem_rsp_data  = 32'h0;
        end else begin
            if (imem_a.imem_req_valid && imem_a.imem_req_ready)
                pend_a.push_back('{addr: imem_a.imem_req_addr, due: cyc_a + lat});
            cyc_a++;
            #1;
            if (pend_a.size() > 0 && pend_a[0].due <= cyc_a) begin
                imem_a.imem_rsp_valid = 1'b1;
                imem_a.imem_rsp_data  = mem_word(pend_a[0].addr);
                void'(pend_a.pop_front());
            end else begin
                imem_a.imem_rsp_valid = 1'b0;
                imem_a.imem_rsp_data  = 32'h0;
            end
        end
    end

    // Memory B: fixed one-cycle latency.
    always @(posedge clk) begin
        logic        fire;
        logic [31:0] addr;
        fire = rst_n && imem_b.imem_req_valid && imem_b.imem_req_ready;
        addr = imem_b.imem_req_addr;
        #1;
        imem_b.imem_rsp_valid = fire;
        imem_b.imem_rsp_data  = fire ? mem_word(addr) : 32'h0;
    end

    // Scoreboard: every instruction taken by decode must be the next expected PC and its word.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pc = 32'h0;
        end else begin
            if (mon_en && if_valid && if_ready) begin
                check("pop_pc", if_pc, exp_pc);
                check("pop_instr", if_instr, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_pops++;
            end
            if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
        end
    end

    initial begin
        int p0;
        int n;
        rst_n          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b1;
        if_ready_b     = 1'b1;
        imem_a.imem_req_ready = 1'b1;
        imem_b.imem_req_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);

        // Reset state
        @(negedge clk);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_req_valid", 32'(imem_a.imem_req_valid), 32'd0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instr, 32'h0);

        // 1. Streaming from reset, one instruction per cycle
        tick();
        rst_n = 1'b1;
        #1;
        check("first_req_valid", 32'(imem_a.imem_req_valid), 32'd1);
        check("first_req_addr", imem_a.imem_req_addr, 32'h0);
        check("wrap_first_addr", imem_b.imem_req_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        check("lat_c0", 32'(if_valid), 32'd0);
        @(negedge clk);
        check("lat_c1", 32'(if_valid), 32'd0);
        @(negedge clk);
        check("first_valid", 32'(if_valid), 32'd1);
        check("first_pc", if_pc, 32'h0);
        check("wrap_pc0", if_pc_b, 32'hFFFF_FFFC);
        @(negedge clk);
        check("wrap_valid1", 32'(if_valid_b), 32'd1);
        check("wrap_pc1", if_pc_b, 32'h0000_0000);
        check("wrap_instr1", if_instr_b, mem_word(32'h0));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("stream_valid", 32'(if_valid), 32'd1);
        end

        // 2. Decode stall: buffer fills, issue stops, release loses nothing
        tick();
        if_ready = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        check("stall_req_valid", 32'(imem_a.imem_req_valid), 32'd0);
        check("stall_if_valid", 32'(if_valid), 32'd1);
        check("stall_outstanding", 32'(pend_a.size()), 32'd0);
        check("stall_head_pc", if_pc, exp_pc);
        tick();
        if_ready = 1'b1;
        p0 = n_pops;
        repeat (6) tick();
        check("release_pops", 32'(n_pops - p0), 32'd6);

        // 3. Redirect with two reads outstanding on a 3-cycle memory
        lat = 3;
        n = 0;
        tick();
        while (pend_a.size() != 2 && n < 30) begin
            tick();
            n++;
        end
        check("two_outstanding", 32'(pend_a.size()), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        wait_valid("redir3_wait");
        check("redir3_pc", if_pc, 32'h100);
        check("redir3_instr", if_instr, mem_word(32'h100));
        repeat (8) tick();

        // 4. Redirect in the same cycle decode takes the head
        lat = 1;
        repeat (4) tick();
        if_ready = 1'b0;
        repeat (4) tick();
        if_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        p0 = n_pops;
        @(negedge clk);
        check("redir4_head_valid", 32'(if_valid), 32'd1);
        tick();
        redirect_valid = 1'b0;
        check("redir4_one_pop", 32'(n_pops - p0), 32'd1);
        @(negedge clk);
        check("redir4_flushed", 32'(if_valid), 32'd0);
        wait_valid("redir4_wait");
        check("redir4_pc", if_pc, 32'h200);
        repeat (4) tick();

`ifdef IFU_MISALIGN_FAULT_EN
        // 6. Misaligned redirect produces one faulting NOP and halts fetch
        mon_en         = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick();
        redirect_valid = 1'b0;
        wait_valid("fault_wait");
        check("fault_pc", if_pc, 32'h102);
        check("fault_instr", if_instr, 32'h0000_0013);
        check("fault_flag", 32'(if_fault), 32'd1);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (imem_a.imem_req_valid || if_valid) n++;
        end
        check("fault_halted", 32'(n), 32'd0);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        tick();
        redirect_valid = 1'b0;
        mon_en         = 1'b1;
        wait_valid("resume_wait");
        check("resume_pc", if_pc, 32'h400);
        check("resume_fault", 32'(if_fault), 32'd0);
`else
        // Misaligned redirect target has its low bits cleared
        redirect_valid = 1'b1;
        redirect_pc    = 32'h306;
        tick();
        redirect_valid = 1'b0;
        wait_valid("misalign_wait");
        check("misalign_pc", if_pc, 32'h304);
        check("misalign_instr", if_instr, mem_word(32'h304));
`endif
        repeat (4) tick();

        // Reset in mid-stream returns to the reset PC
        rst_n = 1'b0;
        #1;
        check("midrst_if_valid", 32'(if_valid), 32'd0);
        check("midrst_req_valid", 32'(imem_a.imem_req_valid), 32'd0);
        check("midrst_if_pc", if_pc, 32'h0);
        tick();
        rst_n = 1'b1;
        wait_valid("midrst_wait");
        check("midrst_first_pc", if_pc, 32'h0);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
